// File: rtl/seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_display_ctrl
//
// Converts CHANNELS binary values into DIGITS-wide active-low 7-segment codes.
// A print request snapshots every channel, then each channel is converted in
// turn with a bit-serial double-dabble. The finished codes collect in a
// staging register that is copied to seg in one edge, so all channels change
// together and seg is stable between done pulses.
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   print   conversion request, sampled every rising edge
//   values  packed inputs, channel k at [k*WIDTH +: WIDTH]
//   seg     packed codes, channel k digit d (d=0 units) at [(k*DIGITS+d)*7 +: 7]
//   busy    high while a conversion is in progress
//   done    one-cycle pulse on the edge that updates seg
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for print (or a pending request); captures snapshot
// LOAD    | load channel magnitude and sign, clear BCD accumulator
// SHIFT   | double-dabble, one bit per cycle, down-counter times WIDTH
// STORE   | format the channel's codes into the staging register
// FINISH  | copy staging to seg, pulse done, drop busy
// -----------------------------------------------------------------------------
module seg7_display_ctrl #(
  parameter int CHANNELS = 3,
  parameter int DIGITS   = 2,
  parameter int WIDTH    = 32,
  parameter int SIGNED   = 0,
  parameter int BLANK    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         print,
  input  logic [WIDTH*CHANNELS-1:0]    values,
  output logic [7*DIGITS*CHANNELS-1:0] seg,
  output logic                         busy,
  output logic                         done
);

  // ceil(WIDTH*0.302)+1 BCD digits always hold a WIDTH-bit magnitude; widen
  // to DIGITS so the formatter can always index every displayed digit.
  localparam int BCD_CALC = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int NBCD     = (BCD_CALC > DIGITS) ? BCD_CALC : DIGITS;
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W    = $clog2(WIDTH);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7*DIGITS*CHANNELS-1:0] SEG_RST = {(DIGITS*CHANNELS){SEG_ZERO}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    STORE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                         state;
  logic [WIDTH*CHANNELS-1:0]      snap;
  logic [7*DIGITS*CHANNELS-1:0]   staging;
  logic [WIDTH-1:0]               bin;
  logic [4*NBCD-1:0]              bcd;
  logic                           neg;
  logic [CNT_W-1:0]               cnt;
  logic [CH_W-1:0]                ch;
  logic                           pending;

  logic [WIDTH-1:0]               cur_val;
  logic [WIDTH-1:0]               cur_mag;
  logic                           cur_neg;
  logic [4*NBCD-1:0]              bcd_adj;
  logic [7*DIGITS-1:0]            store_codes;
  logic                           ovf;
  int                             lim;
  int                             msd;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Two's complement negate of the most negative value yields 2^(WIDTH-1)
  // as an unsigned pattern, which is exactly the magnitude we want.
  always_comb begin
    cur_val = snap[ch*WIDTH +: WIDTH];
    cur_neg = (SIGNED != 0) && cur_val[WIDTH-1];
    cur_mag = cur_neg ? ((~cur_val) + WIDTH'(1)) : cur_val;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Formatter. lim is the number of digits available to the magnitude; a
  // negative value gives one of them up to the minus sign. msd is the highest
  // nonzero magnitude digit (0 when the value is zero), which places both the
  // blanking boundary and the minus sign when blanking is enabled.
  always_comb begin
    store_codes = '0;
    lim         = neg ? (DIGITS - 1) : DIGITS;
    ovf         = neg && (DIGITS == 1);
    msd         = 0;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd[i*4 +: 4] != 4'd0) begin
        if (i >= lim)
          ovf = 1'b1;
        else
          msd = i;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (ovf)
        store_codes[d*7 +: 7] = SEG_DASH;
      else if (neg && (((BLANK != 0) && (d == msd + 1)) ||
                       ((BLANK == 0) && (d == DIGITS - 1))))
        store_codes[d*7 +: 7] = SEG_DASH;
      else if ((BLANK != 0) && (d > msd))
        store_codes[d*7 +: 7] = SEG_BLANK;
      else
        store_codes[d*7 +: 7] = seg_code(bcd[d*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      staging <= SEG_RST;
      seg     <= SEG_RST;
      bin     <= '0;
      bcd     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      ch      <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Any number of requests during a run collapse into one follow-up run.
      if (busy && print)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (print || pending) begin
            snap    <= values;
            busy    <= 1'b1;
            ch      <= '0;
            pending <= 1'b0;
            state   <= LOAD;
          end
        end

        LOAD: begin
          bin   <= cur_mag;
          neg   <= cur_neg;
          bcd   <= '0;
          cnt   <= CNT_W'(WIDTH - 1);
          state <= SHIFT;
        end

        SHIFT: begin
          bcd <= {bcd_adj[4*NBCD-2:0], bin[WIDTH-1]};
          bin <= {bin[WIDTH-2:0], 1'b0};
          if (cnt == '0)
            state <= STORE;
          else
            cnt <= cnt - CNT_W'(1);
        end

        STORE: begin
          staging[ch*7*DIGITS +: 7*DIGITS] <= store_codes;
          if (ch == CH_W'(CHANNELS - 1)) begin
            state <= FINISH;
          end else begin
            ch    <= ch + CH_W'(1);
            state <= LOAD;
          end
        end

        FINISH: begin
          seg   <= staging;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Three instances: defaults, an 8-bit signed variant and a 16-bit signed,
// blanked, 4-digit variant. A decimal reference model predicts busy, done and
// seg for every instance on every cycle; directed sequences pin the model with
// literal codes and latencies, then randomized prints and values follow.
// -----------------------------------------------------------------------------
module tb_seg7_display_ctrl;

  localparam int NI = 3;
  localparam int P_C [NI] = '{3, 3, 2};
  localparam int P_D [NI] = '{2, 2, 4};
  localparam int P_W [NI] = '{32, 8, 16};
  localparam int P_S [NI] = '{0, 1, 1};
  localparam int P_B [NI] = '{0, 0, 1};

  localparam logic [6:0] S_0    = 7'b1000000;
  localparam logic [6:0] S_2    = 7'b0100100;
  localparam logic [6:0] S_3    = 7'b0110000;
  localparam logic [6:0] S_4    = 7'b0011001;
  localparam logic [6:0] S_5    = 7'b0010010;
  localparam logic [6:0] S_7    = 7'b1111000;
  localparam logic [6:0] S_9    = 7'b0010000;
  localparam logic [6:0] S_DASH = 7'b0111111;
  localparam logic [6:0] S_BLNK = 7'b1111111;

  logic          clk;
  logic          rst_n;
  logic [NI-1:0] pr;
  logic [NI-1:0] bz;
  logic [NI-1:0] dn;
  logic [95:0]   vals0;
  logic [23:0]   vals1;
  logic [31:0]   vals2;
  logic [41:0]   seg0;
  logic [41:0]   seg1;
  logic [55:0]   seg2;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  seg7_display_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .print(pr[0]), .values(vals0),
    .seg(seg0), .busy(bz[0]), .done(dn[0])
  );

  seg7_display_ctrl #(.CHANNELS(3), .DIGITS(2), .WIDTH(8), .SIGNED(1), .BLANK(0)) u1 (
    .clk(clk), .rst_n(rst_n), .print(pr[1]), .values(vals1),
    .seg(seg1), .busy(bz[1]), .done(dn[1])
  );

  seg7_display_ctrl #(.CHANNELS(2), .DIGITS(4), .WIDTH(16), .SIGNED(1), .BLANK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .print(pr[2]), .values(vals2),
    .seg(seg2), .busy(bz[2]), .done(dn[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] dec7(input int v);
    case (v)
      0: dec7 = 7'b1000000;
      1: dec7 = 7'b1111001;
      2: dec7 = 7'b0100100;
      3: dec7 = 7'b0110000;
      4: dec7 = 7'b0011001;
      5: dec7 = 7'b0010010;
      6: dec7 = 7'b0000010;
      7: dec7 = 7'b1111000;
      8: dec7 = 7'b0000000;
      default: dec7 = 7'b0010000;
    endcase
  endfunction

  function automatic logic [55:0] zero_seg(input int d);
    logic [55:0] r;
    r = '0;
    for (int p = 0; p < d; p++) r[p*7 +: 7] = S_0;
    return r;
  endfunction

  // Decimal rendering of one raw w-bit value onto d digits.
  function automatic logic [55:0] disp(input longint unsigned raw, input int w,
                                       input int d, input int s, input int b);
    logic [55:0]     r;
    bit              neg;
    longint unsigned mag, pw, q;
    int              nd, ndig;
    r   = '0;
    neg = (s != 0) && (((raw >> (w - 1)) & 64'd1) == 64'd1);
    mag = neg ? ((64'd1 << w) - raw) : raw;
    nd  = neg ? d - 1 : d;
    pw  = 1;
    for (int j = 0; j < nd; j++) pw = pw * 10;
    if (mag >= pw) begin
      for (int p = 0; p < d; p++) r[p*7 +: 7] = S_DASH;
    end else begin
      ndig = 1;
      q = mag / 10;
      while (q != 0) begin
        ndig++;
        q = q / 10;
      end
      q = mag;
      for (int p = 0; p < d; p++) begin
        if (neg && (p == ((b != 0) ? ndig : d - 1)))
          r[p*7 +: 7] = S_DASH;
        else if ((b != 0) && (p >= ndig))
          r[p*7 +: 7] = S_BLNK;
        else
          r[p*7 +: 7] = dec7(int'(q % 10));
        q = q / 10;
      end
    end
    return r;
  endfunction

  function automatic longint unsigned get_raw(input int i, input int k);
    case (i)
      0:       return longint'(vals0[k*32 +: 32]);
      1:       return longint'(vals1[k*8 +: 8]);
      default: return longint'(vals2[k*16 +: 16]);
    endcase
  endfunction

  function automatic logic [55:0] dut_ch(input int i, input int k);
    logic [55:0] r;
    r = '0;
    case (i)
      0:       r[13:0] = seg0[k*14 +: 14];
      1:       r[13:0] = seg1[k*14 +: 14];
      default: r[27:0] = seg2[k*28 +: 28];
    endcase
    return r;
  endfunction

  bit              m_busy [NI];
  bit              m_pend [NI];
  bit              m_done [NI];
  int              m_cnt  [NI];
  longint unsigned m_snap [NI][3];
  logic [55:0]     m_seg  [NI][3];

  // Transaction-level timing: a run lasts CHANNELS*(WIDTH+2)+1 edges from
  // the capture edge; requests seen while busy merge into one follow-up run.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NI; i++) begin
          m_busy[i] = 1'b0;
          m_pend[i] = 1'b0;
          m_done[i] = 1'b0;
          m_cnt[i]  = 0;
          for (int k = 0; k < 3; k++) m_seg[i][k] = zero_seg(P_D[i]);
        end
      end else begin
        for (int i = 0; i < NI; i++) begin
          m_done[i] = 1'b0;
          if (!m_busy[i]) begin
            if (pr[i] || m_pend[i]) begin
              for (int k = 0; k < P_C[i]; k++) m_snap[i][k] = get_raw(i, k);
              m_busy[i] = 1'b1;
              m_pend[i] = 1'b0;
              m_cnt[i]  = P_C[i] * (P_W[i] + 2) + 1;
            end
          end else begin
            if (pr[i]) m_pend[i] = 1'b1;
            m_cnt[i]--;
            if (m_cnt[i] == 0) begin
              m_busy[i] = 1'b0;
              m_done[i] = 1'b1;
              for (int k = 0; k < P_C[i]; k++)
                m_seg[i][k] = disp(m_snap[i][k], P_W[i], P_D[i], P_S[i], P_B[i]);
            end
          end
        end
      end
    end
  end

  // Compare process: every instance, every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("busy%0d", i), 64'(bz[i]), 64'(m_busy[i]));
          check($sformatf("done%0d", i), 64'(dn[i]), 64'(m_done[i]));
          for (int k = 0; k < P_C[i]; k++)
            check($sformatf("seg%0d_ch%0d", i, k), 64'(dut_ch(i, k)), 64'(m_seg[i][k]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int i);
    pr[i] = 1'b1;
    @(negedge clk);
    pr[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (dn[i]) break;
      if (n >= max) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_done%0d: no done within %0d cycles", i, max);
        break;
      end
    end
  endtask

  task automatic count_done(input int i, input int cycles, output int c);
    c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (dn[i]) c++;
    end
  endtask

  task automatic set_raw(input int i, input int k, input longint unsigned v);
    case (i)
      0:       vals0[k*32 +: 32] = v[31:0];
      1:       vals1[k*8 +: 8]   = v[7:0];
      default: vals2[k*16 +: 16] = v[15:0];
    endcase
  endtask

  function automatic longint unsigned rnd_val(input int w);
    longint unsigned mask, v;
    mask = (64'd1 << w) - 1;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 120));
      1: v = longint'($urandom());
      2: v = (64'd1 << w) - longint'($urandom_range(1, 1200));
      default: begin
        case ($urandom_range(0, 11))
          0:  v = 0;
          1:  v = 9;
          2:  v = 10;
          3:  v = 99;
          4:  v = 100;
          5:  v = 999;
          6:  v = 1000;
          7:  v = 9999;
          8:  v = 10000;
          9:  v = 64'd1 << (w - 1);
          10: v = (64'd1 << (w - 1)) - 1;
          default: v = mask;
        endcase
      end
    endcase
    return v & mask;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int c;
    rst_n = 1'b0;
    pr    = '0;
    vals0 = '0;
    vals1 = '0;
    vals2 = '0;
    tick(3);
    cmp_en = 1'b1;

    check("rst_seg0", 64'(seg0), 64'({6{S_0}}));
    check("rst_busy0", 64'(bz[0]), 64'd0);
    check("rst_done0", 64'(dn[0]), 64'd0);
    check("rst_seg2", 64'(seg2), 64'({8{S_0}}));
    rst_n = 1'b1;
    tick(2);

    // Basic conversion on the default instance.
    vals0 = {32'd99, 32'd42, 32'd7};
    pulse(0);
    wait_done(0, 200, n);
    check("lat_default", 64'(n), 64'd103);
    check("seg_conv", 64'(seg0), 64'({S_9, S_9, S_4, S_2, S_0, S_7}));
    tick(2);

    // Overflow and signed rendering.
    vals0[31:0] = 32'd100;
    vals1 = {8'hF6, 8'hFB, 8'd100};
    pr[0] = 1'b1;
    pr[1] = 1'b1;
    @(negedge clk);
    pr = '0;
    wait_done(1, 100, n);
    check("lat_w8", 64'(n), 64'd31);
    check("seg_signed", 64'(seg1), 64'({S_DASH, S_DASH, S_DASH, S_5, S_DASH, S_DASH}));
    wait_done(0, 200, n);
    check("seg_ovf100", 64'(seg0[13:0]), 64'({S_DASH, S_DASH}));
    tick(2);

    vals1[7:0] = 8'h80;
    pulse(1);
    wait_done(1, 100, n);
    check("seg_min128", 64'(seg1[13:0]), 64'({S_DASH, S_DASH}));
    tick(2);

    // Blanking with a leading minus sign.
    vals2 = {16'd0, 16'hFFF9};
    pulse(2);
    wait_done(2, 100, n);
    check("lat_blank", 64'(n), 64'd37);
    check("seg_blank", 64'(seg2),
          64'({S_BLNK, S_BLNK, S_BLNK, S_0, S_BLNK, S_BLNK, S_DASH, S_7}));
    tick(2);

    // Request during a run: first result uses the old snapshot.
    vals0 = {32'd99, 32'd42, 32'd7};
    pulse(0);
    tick(9);
    vals0[31:0] = 32'd3;
    pulse(0);
    wait_done(0, 200, n);
    check("pend_first_lat", 64'(n), 64'd93);
    check("pend_first_seg", 64'(seg0[13:0]), 64'({S_0, S_7}));
    wait_done(0, 200, n);
    check("pend_second_lat", 64'(n), 64'd104);
    check("pend_second_seg", 64'(seg0[13:0]), 64'({S_0, S_3}));
    count_done(0, 150, c);
    check("pend_cleared", 64'(c), 64'd0);

    // Several requests during one run still yield one follow-up run.
    pulse(0);
    tick(19);
    pulse(0);
    tick(19);
    pulse(0);
    tick(19);
    pulse(0);
    count_done(0, 300, c);
    check("pend_x3_runs", 64'(c), 64'd2);
    tick(5);

    // Reset in the middle of a conversion.
    pulse(0);
    tick(49);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_seg0", 64'(seg0), 64'({6{S_0}}));
    check("midrst_busy0", 64'(bz[0]), 64'd0);
    check("midrst_done0", 64'(dn[0]), 64'd0);
    tick(3);
    rst_n = 1'b1;
    count_done(0, 150, c);
    check("midrst_no_done", 64'(c), 64'd0);
    pulse(0);
    wait_done(0, 200, n);
    check("postrst_lat", 64'(n), 64'd103);
    check("postrst_seg", 64'(seg0), 64'({S_9, S_9, S_4, S_2, S_0, S_3}));
    tick(2);

    // Randomized prints and input changes, checked by the model every cycle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        pr[i] = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 9) == 0)
          set_raw(i, int'($urandom_range(0, P_C[i] - 1)), rnd_val(P_W[i]));
      end
      @(negedge clk);
    end
    pr = '0;
    tick(250);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
